// File: rtl/wired_inst_queue.sv
// Circular instruction queue between fetch/decode and the backend rename stage.
// Accepts up to two instructions per cycle and presents the oldest one or two as a compacted packet.
package wired_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pipeline_ctrl_pack_t;

  typedef struct packed {
    logic        redirect;
    logic [31:0] target_pc;
  } bpu_correct_t;
endpackage

module wired_inst_queue
  import wired_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        f_valid_i,
  output logic                        f_ready_o,
  input  logic [1:0]                  f_mask_i,
  input  pipeline_ctrl_pack_t [1:0]   f_pkg_i,
  output logic                        pkg_valid_o,
  input  logic                        pkg_ready_i,
  output logic [1:0]                  pkg_mask_o,
  output pipeline_ctrl_pack_t [1:0]   pkg_o,
  input  bpu_correct_t                bpu_correct_i,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [PW-1:0]       count;
  logic [AW-1:0]       head_idx, head_idx1;
  logic [AW-1:0]       tail_idx, tail_idx1;
  logic                enq_fire, deq_fire;
  logic [1:0]          enq_n, deq_n;
  pipeline_ctrl_pack_t mem_q [DEPTH];
  pipeline_ctrl_pack_t mem_d [DEPTH];

  // Only the redirect flag matters here; the target is for the fetch side.
  logic unused_bpu_target;
  assign unused_bpu_target = ^bpu_correct_i.target_pc;

  always_comb begin
    count     = tail_q - head_q;
    head_idx  = head_q[AW-1:0];
    head_idx1 = head_q[AW-1:0] + AW'(1);
    tail_idx  = tail_q[AW-1:0];
    tail_idx1 = tail_q[AW-1:0] + AW'(1);

    // Ready reserves room for a full pair regardless of mask or same-cycle dequeue.
    f_ready_o   = (count <= PW'(DEPTH - 2)) && !bpu_correct_i.redirect;
    pkg_valid_o = (count != '0);
    if (!pkg_valid_o)          pkg_mask_o = 2'b00;
    else if (count >= PW'(2))  pkg_mask_o = 2'b11;
    else                       pkg_mask_o = 2'b01;
    pkg_o[0] = mem_q[head_idx];
    pkg_o[1] = mem_q[head_idx1];
    count_o  = count;

    enq_fire = f_valid_i && f_ready_o;
    deq_fire = pkg_valid_o && pkg_ready_i;

    mem_d = mem_q;
    enq_n = 2'd0;
    if (enq_fire) begin
      unique case (f_mask_i)
        2'b11: begin
          mem_d[tail_idx]  = f_pkg_i[0];
          mem_d[tail_idx1] = f_pkg_i[1];
          enq_n            = 2'd2;
        end
        2'b01: begin
          mem_d[tail_idx] = f_pkg_i[0];
          enq_n           = 2'd1;
        end
        2'b10: begin
          mem_d[tail_idx] = f_pkg_i[1];
          enq_n           = 2'd1;
        end
        default: enq_n = 2'd0;
      endcase
    end

    if (!deq_fire)                  deq_n = 2'd0;
    else if (pkg_mask_o == 2'b11)   deq_n = 2'd2;
    else                            deq_n = 2'd1;

    tail_d = tail_q + PW'(enq_n);
    head_d = bpu_correct_i.redirect ? tail_q : head_q + PW'(deq_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Payload storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_wired_inst_queue.sv
// Self-checking bench for wired_inst_queue: directed scenarios plus a randomized stream,
// all checked against an in-order instruction queue model.
module tb_wired_inst_queue;
  import wired_pkg::*;

  localparam int DEPTH = 8;

  logic                      clk;
  logic                      rst_n;
  logic                      f_valid_i;
  logic                      f_ready_o;
  logic [1:0]                f_mask_i;
  pipeline_ctrl_pack_t [1:0] f_pkg_i;
  logic                      pkg_valid_o;
  logic                      pkg_ready_i;
  logic [1:0]                pkg_mask_o;
  pipeline_ctrl_pack_t [1:0] pkg_o;
  bpu_correct_t              bpu_correct_i;
  logic [$clog2(DEPTH):0]    count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pipeline_ctrl_pack_t model_q[$];

  wired_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .f_valid_i    (f_valid_i),
    .f_ready_o    (f_ready_o),
    .f_mask_i     (f_mask_i),
    .f_pkg_i      (f_pkg_i),
    .pkg_valid_o  (pkg_valid_o),
    .pkg_ready_i  (pkg_ready_i),
    .pkg_mask_o   (pkg_mask_o),
    .pkg_o        (pkg_o),
    .bpu_correct_i(bpu_correct_i),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic pipeline_ctrl_pack_t mk(input logic [31:0] pc);
    pipeline_ctrl_pack_t p;
    p.pc   = pc;
    p.inst = $urandom;
    return p;
  endfunction

  // Drive one cycle of inputs, check outputs against the model, then advance the model.
  task automatic step(input bit fv, input logic [1:0] fm, input pipeline_ctrl_pack_t s0,
                      input pipeline_ctrl_pack_t s1, input bit rdy, input bit redir,
                      output bit acc);
    int  n;
    bit  exp_rdy;
    logic [1:0] exp_mask;
    f_valid_i                = fv;
    f_mask_i                 = fm;
    f_pkg_i[0]               = s0;
    f_pkg_i[1]               = s1;
    pkg_ready_i              = rdy;
    bpu_correct_i.redirect   = redir;
    bpu_correct_i.target_pc  = $urandom;
    #1;
    n        = model_q.size();
    exp_rdy  = (DEPTH - n >= 2) && !redir;
    exp_mask = (n == 0) ? 2'b00 : (n >= 2) ? 2'b11 : 2'b01;
    chk("f_ready", 64'(f_ready_o), 64'(exp_rdy));
    chk("count", 64'(count_o), 64'(n));
    chk("pkg_valid", 64'(pkg_valid_o), 64'(n != 0));
    chk("pkg_mask", 64'(pkg_mask_o), 64'(exp_mask));
    if (n >= 1) chk("pkg0", pkg_o[0], model_q[0]);
    if (n >= 2) chk("pkg1", pkg_o[1], model_q[1]);
    acc = fv && exp_rdy;
    if (redir) begin
      model_q.delete();
    end else begin
      if (rdy && n > 0) begin
        void'(model_q.pop_front());
        if (n >= 2) void'(model_q.pop_front());
      end
      if (acc) begin
        case (fm)
          2'b11: begin model_q.push_back(s0); model_q.push_back(s1); end
          2'b01: model_q.push_back(s0);
          2'b10: model_q.push_back(s1);
          default: ;
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    int cyc = 0;
    while (model_q.size() > 0 && cyc < 50) begin
      step(1'b0, 2'b00, mk(0), mk(0), 1'b1, 1'b0, acc);
      cyc++;
    end
    #1;
    chk("drain_count", 64'(count_o), 64'd0);
  endtask

  initial begin
    bit acc;
    int sent;
    int cyc;
    int rem;
    logic [1:0] m;
    pipeline_ctrl_pack_t a, b;

    rst_n                   = 1'b0;
    f_valid_i               = 1'b0;
    f_mask_i                = 2'b00;
    f_pkg_i                 = '0;
    pkg_ready_i             = 1'b0;
    bpu_correct_i           = '0;

    // Reset state
    @(negedge clk);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(pkg_valid_o), 64'd0);
    chk("rst_mask", 64'(pkg_mask_o), 64'd0);
    chk("rst_f_ready", 64'(f_ready_o), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pair, latency one cycle
    step(1'b1, 2'b11, mk(32'h1c000000), mk(32'h1c000004), 1'b1, 1'b0, acc);
    chk("lat_pc0", 64'(pkg_o[0].pc), 64'h1c000000);
    chk("lat_pc1", 64'(pkg_o[1].pc), 64'h1c000004);
    step(1'b0, 2'b00, mk(0), mk(0), 1'b1, 1'b0, acc);
    chk("lat_empty", 64'(count_o), 64'd0);

    // Compaction of mask 10 then 01
    step(1'b1, 2'b10, mk(32'hdead0000), mk(32'h1c000104), 1'b0, 1'b0, acc);
    step(1'b1, 2'b01, mk(32'h1c000108), mk(32'hdead0004), 1'b0, 1'b0, acc);
    chk("cmp_mask", 64'(pkg_mask_o), 64'd3);
    chk("cmp_pc0", 64'(pkg_o[0].pc), 64'h1c000104);
    chk("cmp_pc1", 64'(pkg_o[1].pc), 64'h1c000108);
    step(1'b1, 2'b00, mk(0), mk(0), 1'b0, 1'b0, acc);
    drain();

    // Fill to full, then one accept
    for (int i = 0; i < 4; i++)
      step(1'b1, 2'b11, mk(32'h1c000200 + 8 * i), mk(32'h1c000204 + 8 * i), 1'b0, 1'b0, acc);
    chk("full_count", 64'(count_o), 64'd8);
    chk("full_f_ready", 64'(f_ready_o), 64'd0);
    step(1'b1, 2'b11, mk(32'hbad0), mk(32'hbad4), 1'b1, 1'b0, acc);
    chk("after_acc_count", 64'(count_o), 64'd6);
    chk("after_acc_f_ready", 64'(f_ready_o), 64'd1);
    // Count 7 must refuse even a single-slot packet
    step(1'b1, 2'b01, mk(32'h1c000300), mk(0), 1'b0, 1'b0, acc);
    step(1'b1, 2'b01, mk(32'h1c000304), mk(0), 1'b0, 1'b0, acc);
    drain();

    // Randomized 20-instruction stream across pointer wrap
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || model_q.size() > 0) && cyc < 400) begin
      rem = 20 - sent;
      m   = 2'($urandom_range(0, 3));
      if (rem == 0) m = 2'b00;
      else if (rem == 1 && m == 2'b11) m = 2'b01;
      a = mk($urandom);
      b = mk($urandom);
      if (m == 2'b11) begin a = mk(32'h1c001000 + 4 * sent); b = mk(32'h1c001004 + 4 * sent); end
      if (m == 2'b01) a = mk(32'h1c001000 + 4 * sent);
      if (m == 2'b10) b = mk(32'h1c001000 + 4 * sent);
      step(($urandom_range(0, 3) != 0) && rem > 0, m, a, b, 1'($urandom), 1'b0, acc);
      if (acc) sent += (m == 2'b11) ? 2 : (m == 2'b00) ? 0 : 1;
      cyc++;
    end
    chk("stream_sent", 64'(sent), 64'd20);
    drain();

    // Redirect with five entries and a same-cycle fetch
    step(1'b1, 2'b11, mk(32'h1c002000), mk(32'h1c002004), 1'b0, 1'b0, acc);
    step(1'b1, 2'b11, mk(32'h1c002008), mk(32'h1c00200c), 1'b0, 1'b0, acc);
    step(1'b1, 2'b01, mk(32'h1c002010), mk(0), 1'b0, 1'b0, acc);
    chk("pre_redir_count", 64'(count_o), 64'd5);
    step(1'b1, 2'b11, mk(32'h1c003000), mk(32'h1c003004), 1'b0, 1'b1, acc);
    f_valid_i              = 1'b0;
    bpu_correct_i.redirect = 1'b0;
    #1;
    chk("redir_count", 64'(count_o), 64'd0);
    chk("redir_valid", 64'(pkg_valid_o), 64'd0);
    chk("redir_f_ready", 64'(f_ready_o), 64'd1);
    step(1'b0, 2'b00, mk(0), mk(0), 1'b1, 1'b0, acc);

    // Asynchronous reset mid-stream at count 3
    step(1'b1, 2'b11, mk(32'h1c004000), mk(32'h1c004004), 1'b0, 1'b0, acc);
    step(1'b1, 2'b01, mk(32'h1c004008), mk(0), 1'b0, 1'b0, acc);
    chk("pre_rst_count", 64'(count_o), 64'd3);
    f_valid_i = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("async_rst_count", 64'(count_o), 64'd0);
    chk("async_rst_valid", 64'(pkg_valid_o), 64'd0);
    chk("async_rst_mask", 64'(pkg_mask_o), 64'd0);
    chk("async_rst_f_ready", 64'(f_ready_o), 64'd1);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'b11, mk(32'h1c005000), mk(32'h1c005004), 1'b1, 1'b0, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
